mem_access_unit: RTL and testbench

MEM-stage data-memory access controller. It sits directly downstream of the EX/MEM pipeline register and consumes that register's memory control outputs (read enable, write enable, size) plus the EX/MEM address and store-data fields. It runs a request/ready handshake with the data memory, stalls the pipeline while an access is outstanding, and aligns byte and word data. It also flags misaligned word accesses and memory timeouts.

---
 rtl/mem_access_unit_pkg.sv | 18 +
 rtl/mem_access_unit_if.sv | 20 ++
 rtl/mem_access_unit_align.sv | 44 ++++
 rtl/mem_access_unit.sv | 147 ++++++++++++++
 tb/tb_mem_access_unit.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the MEM-stage data-memory access path.
package mem_stage_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } mau_state_e;

   localparam logic       MEM_SIZE_WORD = 1'b0;
   localparam logic       MEM_SIZE_BYTE = 1'b1;
   localparam logic [3:0] BE_WORD       = 4'hF;

   // A word access must sit on a 4-byte boundary; byte accesses never fault.
   function automatic logic word_misaligned(input logic size, input logic [1:0] lane);
      return (size == MEM_SIZE_WORD) && (lane != 2'b00);
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/ready handshake between the MEM-stage access unit and data memory.
interface mem_access_unit_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_rdata, mem_ready
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/mem_access_unit_align.sv
// Little-endian lane steering: store replication / byte enables and load byte extraction.
module byte_lane_align
   import mem_stage_pkg::*;
(
   input  logic        st_size_i,
   input  logic [1:0]  st_lane_i,
   input  logic [31:0] st_data_i,
   output logic [31:0] st_wdata_o,
   output logic [3:0]  st_be_o,
   input  logic        ld_size_i,
   input  logic [1:0]  ld_lane_i,
   input  logic [31:0] ld_rdata_i,
   output logic [31:0] ld_data_o
);

   // Byte stores drive the byte on every lane and let the enables pick the target.
   always_comb begin
      st_wdata_o = st_data_i;
      st_be_o    = BE_WORD;
      if (st_size_i == MEM_SIZE_BYTE) begin
         st_wdata_o = {4{st_data_i[7:0]}};
         st_be_o    = 4'b0001 << st_lane_i;
      end else begin
         st_wdata_o = st_data_i;
         st_be_o    = BE_WORD;
      end
   end

   always_comb begin
      ld_data_o = ld_rdata_i;
      if (ld_size_i == MEM_SIZE_BYTE) begin
         case (ld_lane_i)
            2'd0:    ld_data_o = {24'd0, ld_rdata_i[7:0]};
            2'd1:    ld_data_o = {24'd0, ld_rdata_i[15:8]};
            2'd2:    ld_data_o = {24'd0, ld_rdata_i[23:16]};
            2'd3:    ld_data_o = {24'd0, ld_rdata_i[31:24]};
            default: ld_data_o = 32'd0;
         endcase
      end else begin
         ld_data_o = ld_rdata_i;
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access controller: issues one data-memory request per EX/MEM access,
// stalls the pipeline until completion, and reports misalignment and timeouts.
module mem_access_unit
   import mem_stage_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                mem_read_enable_in,
   input  logic                mem_write_enable_in,
   input  logic                mem_size_in,
   input  logic [31:0]         addr_in,
   input  logic [31:0]         store_data_in,
   mem_access_unit_if.master   mem,
   output logic [31:0]         load_data_out,
   output logic                load_valid_out,
   output logic                stall_out,
   output logic                align_error_out,
   output logic                timeout_error_out
);

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 32'd1);

   mau_state_e  state_q;
   logic        req_q, we_q, size_q;
   logic [1:0]  lane_q;
   logic [31:0] addr_q, wdata_q, load_data_q;
   logic [3:0]  be_q;
   logic [7:0]  cnt_q;
   logic        load_valid_q, align_err_q, timeout_err_q;

   logic        access_s, misalign_s, timeout_hit_s, stall_s;
   logic [31:0] wdata_s, load_data_s;
   logic [3:0]  be_s;

   byte_lane_align u_align (
      .st_size_i  (mem_size_in),
      .st_lane_i  (addr_in[1:0]),
      .st_data_i  (store_data_in),
      .st_wdata_o (wdata_s),
      .st_be_o    (be_s),
      .ld_size_i  (size_q),
      .ld_lane_i  (lane_q),
      .ld_rdata_i (mem.mem_rdata),
      .ld_data_o  (load_data_s)
   );

   // Stall is combinational so the pipeline releases in the same cycle memory completes.
   always_comb begin
      access_s      = mem_read_enable_in | mem_write_enable_in;
      misalign_s    = word_misaligned(mem_size_in, addr_in[1:0]);
      timeout_hit_s = (cnt_q == CNT_LAST);
      stall_s       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (access_s && !misalign_s) stall_s = 1'b1;
            else                         stall_s = 1'b0;
         end
         ST_WAIT: begin
            if (mem.mem_ready || timeout_hit_s) stall_s = 1'b0;
            else                                stall_s = 1'b1;
         end
         default: stall_s = 1'b0;
      endcase
   end

   // Access FSM with registered request fields, result and status pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         req_q         <= 1'b0;
         we_q          <= 1'b0;
         size_q        <= 1'b0;
         lane_q        <= 2'd0;
         addr_q        <= 32'd0;
         wdata_q       <= 32'd0;
         be_q          <= 4'd0;
         cnt_q         <= 8'd0;
         load_data_q   <= 32'd0;
         load_valid_q  <= 1'b0;
         align_err_q   <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         load_valid_q  <= 1'b0;
         align_err_q   <= 1'b0;
         timeout_err_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               cnt_q <= 8'd0;
               if (access_s && misalign_s) begin
                  align_err_q <= 1'b1;
               end else if (access_s) begin
                  // Write wins when both enables are set.
                  req_q   <= 1'b1;
                  we_q    <= mem_write_enable_in;
                  size_q  <= mem_size_in;
                  lane_q  <= addr_in[1:0];
                  addr_q  <= {addr_in[31:2], 2'b00};
                  wdata_q <= wdata_s;
                  be_q    <= be_s;
                  state_q <= ST_WAIT;
               end else begin
                  req_q <= 1'b0;
               end
            end
            ST_WAIT: begin
               if (mem.mem_ready) begin
                  req_q   <= 1'b0;
                  cnt_q   <= 8'd0;
                  state_q <= ST_IDLE;
                  if (!we_q) begin
                     load_data_q  <= load_data_s;
                     load_valid_q <= 1'b1;
                  end else begin
                     load_valid_q <= 1'b0;
                  end
               end else if (timeout_hit_s) begin
                  req_q         <= 1'b0;
                  cnt_q         <= 8'd0;
                  timeout_err_q <= 1'b1;
                  state_q       <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            default: begin
               req_q   <= 1'b0;
               cnt_q   <= 8'd0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign mem.mem_req        = req_q;
   assign mem.mem_we         = we_q;
   assign mem.mem_addr       = addr_q;
   assign mem.mem_wdata      = wdata_q;
   assign mem.mem_be         = be_q;
   assign load_data_out      = load_data_q;
   assign load_valid_out     = load_valid_q;
   assign stall_out          = stall_s;
   assign align_error_out    = align_err_q;
   assign timeout_error_out  = timeout_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized accesses
// compared against a transaction-level model of the access rules.
module tb_mem_access_unit;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        rd, wr, size;
   logic [31:0] addr, sdata;
   logic [31:0] load_data;
   logic        load_valid, stall, align_err, to_err;
   int          n_pass = 0;
   int          n_total = 0;

   mem_access_unit_if mif ();

   mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
      .clk                 (clk),
      .reset               (reset),
      .mem_read_enable_in  (rd),
      .mem_write_enable_in (wr),
      .mem_size_in         (size),
      .addr_in             (addr),
      .store_data_in       (sdata),
      .mem                 (mif),
      .load_data_out       (load_data),
      .load_valid_out      (load_valid),
      .stall_out           (stall),
      .align_error_out     (align_err),
      .timeout_error_out   (to_err)
   );

   always #5 clk = ~clk;

   // One access from detection to the IDLE cycle after completion; entered and left at a negedge.
   task automatic run_access(input logic r, input logic w, input logic sz, input logic [31:0] a,
                             input logic [31:0] sd, input int delay, input logic [31:0] rdat,
                             input string tag);
      logic        mis;
      logic [3:0]  exp_be;
      logic [31:0] exp_wd, exp_ld, exp_addr;
      int          k, obs_stalls, exp_stalls;
      bit          done, timed;
      mis      = (sz == 1'b0) && (a[1:0] != 2'b00);
      exp_addr = a & 32'hFFFF_FFFC;
      exp_be   = sz ? (4'd1 << a[1:0]) : 4'hF;
      exp_wd   = sz ? ({24'd0, sd[7:0]} * 32'h0101_0101) : sd;
      exp_ld   = sz ? ((rdat >> {a[1:0], 3'b000}) & 32'h0000_00FF) : rdat;
      rd = r; wr = w; size = sz; addr = a; sdata = sd; mif.mem_ready = 1'b0;
      #1;
      n_total++; if (stall !== !mis) $display("FAIL %s stall_detect: got %b want %b", tag, stall, !mis); else n_pass++;
      if (mis) begin
         @(negedge clk);
         rd = 1'b0; wr = 1'b0;
         n_total++; if (align_err !== 1'b1) $display("FAIL %s align_pulse: got %b want 1", tag, align_err); else n_pass++;
         n_total++; if (mif.mem_req !== 1'b0) $display("FAIL %s align_noreq: got %b want 0", tag, mif.mem_req); else n_pass++;
         @(negedge clk);
         n_total++; if (align_err !== 1'b0) $display("FAIL %s align_single: got %b want 0", tag, align_err); else n_pass++;
         n_total++; if (mif.mem_req !== 1'b0) $display("FAIL %s align_noreq2: got %b want 0", tag, mif.mem_req); else n_pass++;
      end else begin
         obs_stalls = (stall === 1'b1) ? 1 : 0;
         exp_stalls = (delay < TO) ? delay + 1 : TO;
         k = 0; done = 1'b0; timed = 1'b0;
         while (!done) begin
            @(negedge clk);
            n_total++; if (mif.mem_req !== 1'b1) $display("FAIL %s req_high: got %b want 1 (cycle %0d)", tag, mif.mem_req, k); else n_pass++;
            if (k == 0) begin
               n_total++; if (mif.mem_addr !== exp_addr) $display("FAIL %s mem_addr: got %h want %h", tag, mif.mem_addr, exp_addr); else n_pass++;
               n_total++; if (mif.mem_we !== w) $display("FAIL %s mem_we: got %b want %b", tag, mif.mem_we, w); else n_pass++;
               n_total++; if (mif.mem_be !== exp_be) $display("FAIL %s mem_be: got %h want %h", tag, mif.mem_be, exp_be); else n_pass++;
               if (w) begin
                  n_total++; if (mif.mem_wdata !== exp_wd) $display("FAIL %s mem_wdata: got %h want %h", tag, mif.mem_wdata, exp_wd); else n_pass++;
               end
            end
            mif.mem_ready = (k == delay);
            mif.mem_rdata = (k == delay) ? rdat : $urandom;
            #1;
            done  = (k == delay) || (k == TO - 1);
            timed = done && (k != delay);
            n_total++; if (stall !== !done) $display("FAIL %s stall_wait: got %b want %b (cycle %0d)", tag, stall, !done, k); else n_pass++;
            if (stall === 1'b1) obs_stalls++;
            k++;
         end
         @(negedge clk);
         mif.mem_ready = 1'b0; rd = 1'b0; wr = 1'b0;
         n_total++; if (obs_stalls != exp_stalls) $display("FAIL %s stall_count: got %0d want %0d", tag, obs_stalls, exp_stalls); else n_pass++;
         n_total++; if (mif.mem_req !== 1'b0) $display("FAIL %s req_drop: got %b want 0", tag, mif.mem_req); else n_pass++;
         n_total++; if (load_valid !== (r && !w && !timed)) $display("FAIL %s load_valid: got %b want %b", tag, load_valid, r && !w && !timed); else n_pass++;
         n_total++; if (to_err !== timed) $display("FAIL %s timeout_err: got %b want %b", tag, to_err, timed); else n_pass++;
         n_total++; if (align_err !== 1'b0) $display("FAIL %s align_quiet: got %b want 0", tag, align_err); else n_pass++;
         if (r && !w && !timed) begin
            n_total++; if (load_data !== exp_ld) $display("FAIL %s load_data: got %h want %h", tag, load_data, exp_ld); else n_pass++;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; rd = 1'b0; wr = 1'b0; size = 1'b0; addr = 32'd0; sdata = 32'd0;
      mif.mem_ready = 1'b0; mif.mem_rdata = 32'd0;
      repeat (2) @(negedge clk);
      n_total++; if ({mif.mem_req, mif.mem_we, mif.mem_be} !== 6'd0) $display("FAIL reset_ctrl: got %b want 0", {mif.mem_req, mif.mem_we, mif.mem_be}); else n_pass++;
      n_total++; if ({mif.mem_addr, mif.mem_wdata, load_data} !== 96'd0) $display("FAIL reset_data: got %h want 0", {mif.mem_addr, mif.mem_wdata, load_data}); else n_pass++;
      n_total++; if ({load_valid, stall, align_err, to_err} !== 4'd0) $display("FAIL reset_status: got %b want 0", {load_valid, stall, align_err, to_err}); else n_pass++;
      reset = 1'b0;
   endtask

   task automatic test_directed();
      run_access(1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'd0,          0, 32'hDEAD_BEEF, "word_load");
      run_access(1'b0, 1'b1, 1'b1, 32'h0000_0203, 32'h1234_56AB, 1, 32'h5555_5555, "byte_store");
      run_access(1'b1, 1'b0, 1'b1, 32'h0000_0006, 32'd0,          0, 32'h1122_3344, "byte_load");
      run_access(1'b1, 1'b0, 1'b0, 32'h0000_0102, 32'd0,          0, 32'h0,         "misaligned");
      run_access(1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'd0,     TO + 3, 32'hCAFE_F00D, "timeout");
      run_access(1'b1, 1'b0, 1'b0, 32'h0000_0044, 32'd0,     TO - 1, 32'h0BAD_CAFE, "ready_at_limit");
   endtask

   task automatic test_back_to_back();
      run_access(1'b0, 1'b1, 1'b0, 32'h0000_1000, 32'hA5A5_0001, 0, 32'd0,         "b2b_store");
      run_access(1'b1, 1'b0, 1'b1, 32'h0000_1001, 32'd0,         0, 32'h8899_AABB, "b2b_byte_load");
      run_access(1'b1, 1'b0, 1'b0, 32'h0000_1004, 32'd0,         2, 32'h7654_3210, "b2b_word_load");
   endtask

   task automatic test_idle_ready_ignored();
      rd = 1'b0; wr = 1'b0; mif.mem_ready = 1'b1; mif.mem_rdata = 32'hFFFF_FFFF;
      repeat (3) begin
         @(negedge clk);
         n_total++; if ({load_valid, mif.mem_req, stall, to_err} !== 4'd0) $display("FAIL idle_ready: got %b want 0", {load_valid, mif.mem_req, stall, to_err}); else n_pass++;
      end
      mif.mem_ready = 1'b0;
   endtask

   task automatic test_reset_in_wait();
      rd = 1'b1; wr = 1'b1; size = 1'b0; addr = 32'h0000_0300; sdata = 32'h0F0F_0F0F; mif.mem_ready = 1'b0;
      #1;
      n_total++; if (stall !== 1'b1) $display("FAIL rst_wait_stall: got %b want 1", stall); else n_pass++;
      @(negedge clk);
      n_total++; if ({mif.mem_req, mif.mem_we} !== 2'b11) $display("FAIL rst_wait_we: got %b want 11", {mif.mem_req, mif.mem_we}); else n_pass++;
      reset = 1'b1; rd = 1'b0; wr = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      n_total++; if ({mif.mem_req, mif.mem_we, mif.mem_be, mif.mem_addr, mif.mem_wdata} !== 70'd0) $display("FAIL rst_wait_clear: got %h want 0", {mif.mem_req, mif.mem_we, mif.mem_be, mif.mem_addr, mif.mem_wdata}); else n_pass++;
      n_total++; if ({load_valid, stall, align_err, to_err} !== 4'd0) $display("FAIL rst_wait_status: got %b want 0", {load_valid, stall, align_err, to_err}); else n_pass++;
      @(negedge clk);
      n_total++; if ({load_valid, align_err, to_err, mif.mem_req} !== 4'd0) $display("FAIL rst_wait_quiet: got %b want 0", {load_valid, align_err, to_err, mif.mem_req}); else n_pass++;
   endtask

   task automatic test_random();
      logic [1:0]  sel;
      logic        sz;
      logic [31:0] a;
      int          d;
      for (int i = 0; i < 60; i++) begin
         sel = 2'($urandom_range(1, 3));
         sz  = 1'($urandom_range(0, 1));
         a   = $urandom;
         if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
         d   = int'($urandom_range(0, TO + 1));
         run_access(sel[0], sel[1], sz, a, $urandom, d, $urandom, "random");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_idle_ready_ignored();
      test_reset_in_wait();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
